fetch_unit: RTL

- Parametrised, decoupled instruction-fetch stage for the pipelined LEGv8 core; successor to the single-cycle PC/PC+4/branch-mux fetch.
- Issues sequential word fetches to an instruction memory with a request/grant and in-order response handshake.
- Buffers returned instructions in a small FIFO and presents {pc, instr} to decode with valid/ready.
- A redirect (taken branch/flush) reloads the PC, empties the buffer and discards stale in-flight responses.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the instruction fetch stage
package fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int DEF_ADDR_W  = 64;
  localparam int DEF_INSTR_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FULL,
    S_FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous instruction FIFO with flush, count, full and empty
module fetch_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 96
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [DATA_W-1:0]      head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy update; flush empties the queue in one cycle
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop) begin
        count <= count + (AW+1)'(1);
      end else if (!do_push && do_pop) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - decoupled LEGv8 fetch stage; FETCH_MISALIGN_CHK_EN adds misalign_o and S_FAULT
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 4,
  parameter int                MAX_OUT  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [ADDR_W-1:0]  out_pc_o,
  output logic [INSTR_W-1:0] out_instr_o
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic               misalign_o
`endif
);

  localparam int                OW    = $clog2(MAX_OUT + 1);
  localparam int                FW    = $clog2(DEPTH) + 1;
  localparam logic [OW-1:0]     ONE_O = OW'(1);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INSTR_BYTES);

  fetch_state_t                state;
  logic [ADDR_W-1:0]           pc;
  logic [ADDR_W-1:0]           resp_pc;
  logic [OW-1:0]               total_out;
  logic [OW-1:0]               live_out;
  logic [OW-1:0]               drop_cnt;
  logic [OW-1:0]               total_nxt;
  logic [FW-1:0]               fifo_count;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [ADDR_W+INSTR_W-1:0]   head;
  logic                        issue_ok;
  logic                        fire;
  logic                        rsp;
  logic                        accept;
  logic                        redirect_take;
  logic                        do_pop;

  // Live requests reserve a FIFO slot so every kept response has room when it lands
  assign issue_ok = !fifo_full
                    && (int'(live_out) + int'(fifo_count) < DEPTH)
                    && (int'(total_out) < MAX_OUT);

  assign redirect_take = redirect_i && (state != S_IDLE);
  assign imem_req_o    = (state == S_RUN) && issue_ok && !redirect_i;
  assign imem_addr_o   = pc;
  assign fire          = imem_req_o && imem_gnt_i;
  // With nothing in flight a response can only be a leftover from before reset
  assign rsp           = imem_rvalid_i && (total_out != '0);
  assign accept        = rsp && (drop_cnt == '0);
  assign do_pop        = out_valid_o && out_ready_i && !redirect_take;

  assign out_valid_o = !fifo_empty;
  assign out_pc_o    = out_valid_o ? head[ADDR_W+INSTR_W-1:INSTR_W] : '0;
  assign out_instr_o = out_valid_o ? head[INSTR_W-1:0] : '0;

  // Outstanding count after this cycle's grant and response
  always_comb begin
    total_nxt = total_out;
    if (fire && !rsp) begin
      total_nxt = total_out + ONE_O;
    end else if (!fire && rsp) begin
      total_nxt = total_out - ONE_O;
    end
  end

  // Fetch state machine; a redirect restarts fetch from any state but S_IDLE
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_o <= 1'b0;
`endif
    end else if (redirect_take) begin
`ifdef FETCH_MISALIGN_CHK_EN
      if (redirect_pc_i[1:0] != 2'b00) begin
        state      <= S_FAULT;
        misalign_o <= 1'b1;
      end else begin
        state      <= S_RUN;
        misalign_o <= 1'b0;
      end
`else
      state <= S_RUN;
`endif
    end else begin
      case (state)
        S_IDLE:  state <= S_RUN;
        S_RUN:   if (!issue_ok) state <= S_FULL;
        S_FULL:  if (issue_ok) state <= S_RUN;
        default: state <= state;
      endcase
    end
  end

  // Request and response PCs; the response PC only advances on kept responses
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc      <= RESET_PC;
      resp_pc <= RESET_PC;
    end else if (redirect_take) begin
      pc      <= redirect_pc_i;
      resp_pc <= redirect_pc_i;
    end else begin
      if (fire)   pc      <= pc + STEP;
      if (accept) resp_pc <= resp_pc + STEP;
    end
  end

  // In-flight bookkeeping: all outstanding, those still wanted, and those to discard
  always_ff @(posedge clk) begin
    if (!reset) begin
      total_out <= '0;
      live_out  <= '0;
      drop_cnt  <= '0;
    end else begin
      total_out <= total_nxt;
      if (redirect_take) begin
        live_out <= '0;
        drop_cnt <= total_nxt;
      end else begin
        if (fire && !accept) begin
          live_out <= live_out + ONE_O;
        end else if (!fire && accept) begin
          live_out <= live_out - ONE_O;
        end
        if (rsp && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - ONE_O;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ADDR_W + INSTR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept && !redirect_take),
    .push_data ({resp_pc, imem_rdata_i}),
    .pop       (do_pop),
    .flush     (redirect_take),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
